// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and optional first-word-fall-through read.
module sync_fifo_param #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      we,
   input  logic [DATA_W-1:0]         data_in,
   input  logic                      re,
   output logic [DATA_W-1:0]         data_out,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow,
   output logic                      underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] AF = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE = CW'(AE_LEVEL);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0] wptr, rptr, wptr_n, rptr_n, count_n;
   logic rd_ok, wr_ok;
   // a full FIFO still accepts a write when a read frees the slot on the same edge
   always_comb begin
      rd_ok   = re & ~empty;
      wr_ok   = we & (~full | rd_ok);
      wptr_n  = wptr + CW'(wr_ok);
      rptr_n  = rptr + CW'(rd_ok);
      count_n = wptr_n - rptr_n;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_full  <= (AF == '0);
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wptr         <= wptr_n;
         rptr         <= rptr_n;
         count        <= count_n;
         empty        <= (wptr_n == rptr_n);
         full         <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
         almost_full  <= (count_n >= AF);
         almost_empty <= (count_n <= AE);
         overflow     <= we & ~wr_ok;
         underflow    <= re & ~rd_ok;
      end
   always_ff @(posedge clk)
      if (wr_ok) mem[wptr[AW-1:0]] <= data_in;
   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = mem[rptr[AW-1:0]];
      end else begin : g_reg
         always_ff @(posedge clk or negedge reset)
            if (!reset) data_out <= '0;
            else if (rd_ok) data_out <= mem[rptr[AW-1:0]];
      end
   endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives a registered-read and an FWFT instance with identical
// stimulus and compares both against a queue-based reference model.
module tb_sync_fifo_param;
   localparam int DW = 32, D = 8, AFL = 6, AEL = 1;
   logic clk = 0, reset = 1, we = 0, re = 0;
   logic [DW-1:0] din = 0;
   logic [DW-1:0] dout0, dout1;
   logic full0, empty0, af0, ae0, ovf0, udf0;
   logic full1, empty1, af1, ae1, ovf1, udf1;
   logic [3:0] cnt0, cnt1;
   int tests = 0, fails = 0;
   logic [31:0] q[$];
   logic [31:0] exp_dout = 0;
   logic exp_ovf = 0, exp_udf = 0;
   always #5 clk = ~clk;
   sync_fifo_param #(.DATA_W(DW), .DEPTH(D), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0)) u0 (
      .clk(clk), .reset(reset), .we(we), .data_in(din), .re(re), .data_out(dout0),
      .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
      .count(cnt0), .overflow(ovf0), .underflow(udf0));
   sync_fifo_param #(.DATA_W(DW), .DEPTH(D), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1)) u1 (
      .clk(clk), .reset(reset), .we(we), .data_in(din), .re(re), .data_out(dout1),
      .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
      .count(cnt1), .overflow(ovf1), .underflow(udf1));
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic check_all();
      int n;
      n = q.size();
      check("count0", 32'(cnt0), 32'(n));
      check("count1", 32'(cnt1), 32'(n));
      check("full0", 32'(full0), 32'(n == D));
      check("full1", 32'(full1), 32'(n == D));
      check("empty0", 32'(empty0), 32'(n == 0));
      check("empty1", 32'(empty1), 32'(n == 0));
      check("almost_full0", 32'(af0), 32'(n >= AFL));
      check("almost_full1", 32'(af1), 32'(n >= AFL));
      check("almost_empty0", 32'(ae0), 32'(n <= AEL));
      check("almost_empty1", 32'(ae1), 32'(n <= AEL));
      check("overflow0", 32'(ovf0), 32'(exp_ovf));
      check("overflow1", 32'(ovf1), 32'(exp_ovf));
      check("underflow0", 32'(udf0), 32'(exp_udf));
      check("underflow1", 32'(udf1), 32'(exp_udf));
      check("data_out_reg", dout0, exp_dout);
      if (n > 0) check("data_out_fwft", dout1, q[0]);
   endtask
   task automatic step(input logic w, input logic [31:0] d, input logic r);
      logic rd_ok, wr_ok;
      we = w;
      din = d;
      re = r;
      @(posedge clk);
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < D) || rd_ok);
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      exp_ovf = w && !wr_ok;
      exp_udf = r && !rd_ok;
      #1 check_all();
   endtask
   task automatic model_reset();
      q.delete();
      exp_dout = 0;
      exp_ovf = 0;
      exp_udf = 0;
   endtask
   initial begin
      int v;
      // reset and idle
      #1 reset = 0;
      #1 check_all();
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk) reset = 1;
      repeat (3) step(0, 0, 0);
      // fill with 0x10..0x17, then drain
      for (int i = 0; i < 8; i++) step(1, 32'h10 + i, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1);
      step(0, 0, 0);
      // overflow on full, then full write+read with 0xAA
      for (int i = 0; i < 8; i++) step(1, 32'h20 + i, 0);
      step(1, 32'hDEAD, 0);
      step(0, 0, 0);
      step(1, 32'hAA, 1);
      for (int i = 0; i < 8; i++) step(0, 0, 1);
      // underflow on empty, and empty write+read
      step(0, 0, 1);
      step(0, 0, 0);
      step(1, 32'h77, 1);
      step(0, 0, 1);
      // wrap: alternating bursts of 5 writes / 5 reads
      v = 0;
      for (int b = 0; b < 20; b++)
         for (int i = 0; i < 5; i++)
            if (b % 2 == 0) begin
               step(1, v, 0);
               v++;
            end else step(0, 0, 1);
      // random traffic, write-heavy then read-heavy
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 99) < 65, $urandom, $urandom_range(0, 99) < 40);
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 99) < 65);
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);
      // FWFT visibility, then async reset mid-burst
      while (q.size() > 0) step(0, 0, 1);
      step(1, 32'h55, 0);
      step(0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 32'h60 + i, 0);
      we = 0;
      re = 0;
      reset = 0;
      model_reset();
      #1 check_all();
      @(posedge clk);
      #1 check_all();
      @(negedge clk) reset = 1;
      for (int i = 0; i < 4; i++) step(1, 32'hC0 + i, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
